seq_shift_add_multiplier: RTL and testbench

//  Parametrised sequential unsigned/signed multiplier: W x W -> 2W product, one partial-product row per cycle.

---
 rtl/seq_mul_pkg.sv | 24 ++
 rtl/seq_mul_pp_row.sv | 15 +
 rtl/seq_shift_add_multiplier.sv | 148 ++++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared types and constants for the sequential shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_DEFAULT = 4;

    // Ceiling log2, used to size the iteration counter (w >= 2).
    function automatic int clog2_w(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < w) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mul_pp_row.sv
// seq_mul_pp_row: one partial-product row, acc + (en ? addend : 0).
// Purely combinational; the multiplier reuses a single instance every cycle.
module seq_mul_pp_row #(
    parameter int PW = 8
) (
    input  logic [PW-1:0] acc,
    input  logic [PW-1:0] addend,
    input  logic          en,
    output logic [PW-1:0] sum
);

    // Conditional add of the current shifted multiplicand.
    assign sum = acc + (en ? addend : '0);

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: sequential W x W -> 2W shift-and-add multiplier with
// valid/ready handshakes on both sides. One partial-product row per BUSY cycle,
// plus one final cycle that publishes the product, giving a fixed W+1 latency.
// Build option: define SEQ_MUL_SIGNED_EN to add the in_signed port and
// two's-complement operand support (sign-magnitude internally).
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready=1, out_p holds last product
//  BUSY  | accumulating one partial-product row per cycle, then publishing
//  DONE  | out_valid=1, product held until out_ready
module seq_shift_add_multiplier
    import seq_mul_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic           in_signed,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic           busy
);

    localparam int CNT_W = clog2_w(W);
    localparam int PW    = 2 * W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic             last;

    logic             accept;
    logic [W-1:0]     a_load;
    logic [W-1:0]     b_load;
    logic [W-1:0]     bit_sel;
    logic             row_en;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    row_sum;
    logic [PW-1:0]    result;

    // DONE with out_ready frees the slot in the same cycle, allowing back-to-back accepts.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Select multiplier bit cnt and shift the multiplicand into position for this row.
    assign bit_sel = W'(1) << cnt;
    assign row_en  = |(mplier & bit_sel);
    assign addend  = {{W{1'b0}}, mcand} << cnt;

    seq_mul_pp_row #(
        .PW (PW)
    ) u_pp_row (
        .acc    (acc),
        .addend (addend),
        .en     (row_en),
        .sum    (row_sum)
    );

`ifdef SEQ_MUL_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg;

    // Store magnitudes; the most negative value maps onto 2^(W-1), which fits unsigned.
    assign a_neg  = in_signed & in_a[W-1];
    assign b_neg  = in_signed & in_b[W-1];
    assign a_load = a_neg ? -in_a : in_a;
    assign b_load = b_neg ? -in_b : in_b;
    assign result = neg ? -acc : acc;

    // Result sign captured with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= a_neg ^ b_neg;
        end
    end
`else
    assign a_load = in_a;
    assign b_load = in_b;
    assign result = acc;
`endif

    // Control FSM, iteration counter, operand/accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            last      <= 1'b0;
            out_p     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= BUSY;
            mcand     <= a_load;
            mplier    <= b_load;
            acc       <= '0;
            cnt       <= '0;
            last      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                end
                BUSY: begin
                    if (!last) begin
                        acc <= row_sum;
                        if (cnt == CNT_LAST) begin
                            last <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        state     <= DONE;
                        out_p     <= result;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: scoreboard bench for a W=4 and a W=16 instance.
// Honours SEQ_MUL_SIGNED_EN in the same way as the design.
module tb_seq_shift_add_multiplier;

`ifdef SEQ_MUL_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif
    localparam int W4  = 4;
    localparam int W16 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, in_valid, in_ready, out_valid, out_ready, busy, in_signed;
    logic [3:0] in_a, in_b;
    logic [7:0] out_p;

    logic        rst16, in_valid16, in_ready16, out_valid16, out_ready16, busy16, in_signed16;
    logic [15:0] in_a16, in_b16;
    logic [31:0] out_p16;

    seq_shift_add_multiplier #(.W(W4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef SEQ_MUL_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    seq_shift_add_multiplier #(.W(W16)) dut16 (
        .clk       (clk),
        .rst       (rst16),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_a      (in_a16),
        .in_b      (in_b16),
`ifdef SEQ_MUL_SIGNED_EN
        .in_signed (in_signed16),
`endif
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_p     (out_p16),
        .busy      (busy16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference product, masked to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn, input int w);
        longint sa, sb, p;
        logic [63:0] mask;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (sgn && SIGNED_BUILD) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        p    = sa * sb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    // W=4 scoreboard: push at accept, pop at output handshake, check latency on each rise.
    logic [63:0] q4[$];
    int  acc_cyc4 = 0;
    bit  ov_prev4 = 1'b0;
    int  b2b_cnt  = 0;
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            ov_prev4 = 1'b0;
        end else begin
            if (out_valid && !ov_prev4) chk("latency4", 64'(cyc - acc_cyc4), 64'(W4 + 1));
            ov_prev4 = out_valid;
            if (out_valid && out_ready && in_valid && in_ready) b2b_cnt++;
            if (out_valid && out_ready) begin
                chk("sb_nonempty4", 64'(q4.size() != 0), 64'd1);
                if (q4.size() != 0) chk("product4", 64'(out_p), q4.pop_front());
            end
            if (in_valid && in_ready) begin
                q4.push_back(ref_mul(32'(in_a), 32'(in_b), in_signed, W4));
                acc_cyc4 = cyc + 1;
            end
        end
    end

    // W=16 scoreboard.
    logic [63:0] q16[$];
    int  acc_cyc16 = 0;
    bit  ov_prev16 = 1'b0;
    bit  done16    = 1'b0;
    always @(negedge clk) begin
        if (!rst16) begin
            if (out_valid16 && !ov_prev16) begin
                chk("latency16", 64'(cyc - acc_cyc16), 64'(W16 + 1));
                chk("busy16_done", 64'(busy16), 64'd0);
            end
            ov_prev16 = out_valid16;
            if (out_valid16 && out_ready16) begin
                chk("sb_nonempty16", 64'(q16.size() != 0), 64'd1);
                if (q16.size() != 0) chk("product16", 64'(out_p16), q16.pop_front());
            end
            if (in_valid16 && in_ready16) begin
                q16.push_back(ref_mul(32'(in_a16), 32'(in_b16), in_signed16, W16));
                acc_cyc16 = cyc + 1;
            end
        end
    end

    bit auto_rdy = 1'b0;

    // Called in the posedge+1 phase; returns in the posedge+1 phase just after the accept edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input bit s);
        int n;
        n = 0;
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(posedge clk); #1;
            if (auto_rdy && n >= 3) out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q4.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 64'(q4.size()), 64'd0);
    endtask

    initial begin
        int  n;
        bit  ov_seen;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_p", 64'(out_p), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        drive(4'hF, 4'hF, 1'b0);
        wait_drain();
        drive(4'h0, 4'hB, 1'b0);
        wait_drain();

        // Backpressure: product held, no accepts, stray in_valid ignored.
        out_ready = 1'b0;
        drive(4'd13, 4'd11, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("hold_reached", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_a = 4'd2; in_b = 4'd2;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_p", 64'(out_p), 64'h8F);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain();

        // Back-to-back: second accept on the handshake cycle of the first.
        b2b_cnt = 0;
        drive(4'd3, 4'd5, 1'b0);
        drive(4'd6, 4'd7, 1'b0);
        wait_drain();
        chk("b2b_overlap", 64'(b2b_cnt), 64'd1);

        // Abort during BUSY row 2.
        drive(4'd9, 4'd9, 1'b0);
        @(negedge clk);
        chk("busy_high", 64'(busy), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_p", 64'(out_p), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ov_seen = ov_seen | out_valid;
        end
        chk("abort_no_output", 64'(ov_seen), 64'd0);
        @(posedge clk); #1;

`ifdef SEQ_MUL_SIGNED_EN
        drive(4'h8, 4'h8, 1'b1);
        drive(4'h8, 4'h7, 1'b1);
        drive(4'h3, 4'hF, 1'b1);
        drive(4'h8, 4'h8, 1'b0);
        wait_drain();
`endif

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(4'(a), 4'(b), 1'b0);
            end
        end
        wait_drain();

        auto_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        auto_rdy = 1'b0;
        wait_drain();

        n = 0;
        while (!done16 && n < 40000) begin @(posedge clk); n++; end
        chk("w16_done", 64'(done16), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // W=16 random regression with corner operands mixed in.
    initial begin
        int n16;
        logic [15:0] a, b;
        rst16 = 1'b1; in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_signed16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst16 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case (i % 8)
                0: a = 16'h0000;
                1: a = 16'h0001;
                2: a = 16'hFFFF;
                3: a = 16'h8000;
                default: ;
            endcase
            case ((i / 8) % 6)
                0: b = 16'h0000;
                1: b = 16'h0001;
                2: b = 16'hFFFF;
                3: b = 16'h8000;
                default: ;
            endcase
            in_a16 = a; in_b16 = b; in_valid16 = 1'b1;
            in_signed16 = SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
            n16 = 0;
            while (1) begin
                @(negedge clk);
                if (in_ready16) break;
                n16++;
                if (n16 > 100) begin
                    chk("accept_timeout16", 64'(in_ready16), 64'd1);
                    break;
                end
            end
            @(posedge clk); #1;
            in_valid16 = 1'b0;
        end
        n16 = 0;
        while ((q16.size() != 0 || out_valid16) && n16 < 100) begin @(posedge clk); #1; n16++; end
        chk("drain16", 64'(q16.size()), 64'd0);
        done16 = 1'b1;
    end

endmodule
